// File: rtl/fxp_pkg.sv
// Shared fixed-point helpers for the MAC datapath: symmetric saturation bounds,
// the saturated-value struct and the rounding constant.
package fxp_pkg;

  localparam int FXP_WMAX = 32;

  typedef struct packed {
    logic signed [FXP_WMAX-1:0] value;
    logic                       sat;
  } fxp_sat_t;

  function automatic longint FXP_MAX(input int w);
    return (longint'(1) <<< (w - 1)) - longint'(1);
  endfunction

  // Symmetric range: the most negative code is never produced.
  function automatic longint FXP_MIN(input int w);
    return -FXP_MAX(w);
  endfunction

  function automatic longint fxp_round_const(input int frac);
    return longint'(1) <<< (frac - 1);
  endfunction

endpackage

// File: rtl/fxp_round_sat.sv
// Combinational 2W-bit to W-bit rescale: optional round-half-up (FXP_MAC_ROUND_EN),
// arithmetic shift by FRAC, then clamp to the symmetric Q range.
module fxp_round_sat
  import fxp_pkg::*;
#(
  parameter int W    = 16,
  parameter int FRAC = 9
) (
  input  logic signed [2*W-1:0] din,
  output logic signed [W-1:0]   dout,
  output logic                  sat
);

  localparam int XW = 2 * W + 1;
  localparam logic signed [XW-1:0] MAX_X = XW'(FXP_MAX(W));
  localparam logic signed [XW-1:0] MIN_X = XW'(FXP_MIN(W));
`ifdef FXP_MAC_ROUND_EN
  localparam logic signed [XW-1:0] RND_X = XW'(fxp_round_const(FRAC));
`endif

  logic signed [XW-1:0] rounded;
  logic signed [XW-1:0] shifted;

  // One guard bit keeps the rounding add from wrapping on the largest product.
  always_comb begin
    rounded = XW'(din);
`ifdef FXP_MAC_ROUND_EN
    rounded = rounded + RND_X;
`endif
    shifted = rounded >>> FRAC;
    sat     = 1'b0;
    dout    = shifted[W-1:0];
    if (shifted > MAX_X) begin
      dout = MAX_X[W-1:0];
      sat  = 1'b1;
    end else if (shifted < MIN_X) begin
      dout = MIN_X[W-1:0];
      sat  = 1'b1;
    end
  end

endmodule

// File: rtl/fxp_mac_pipe.sv
// Four-stage signed fixed-point MAC with per-frame saturating accumulation.
// Build option FXP_MAC_ROUND_EN selects round-half-up instead of truncation in S3.
module fxp_mac_pipe
  import fxp_pkg::*;
#(
  parameter int W    = 16,
  parameter int FRAC = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enable,
  input  logic         clear,
  input  logic         in_valid,
  input  logic         in_last,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  output logic [W-1:0] acc_data,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic         out_sat
);

  localparam int SW = FXP_WMAX + 1;
  localparam logic signed [SW-1:0] SUM_MAX = SW'(FXP_MAX(W));
  localparam logic signed [SW-1:0] SUM_MIN = SW'(FXP_MIN(W));

  logic signed [W-1:0]   a1, b1;
  logic                  v1, l1;
  logic signed [2*W-1:0] prod2;
  logic                  v2, l2;
  fxp_sat_t              p3;
  logic                  v3, l3;

  logic signed [W-1:0]   acc;
  logic                  first;
  logic                  frame_sat;

  logic signed [W-1:0]   rs_value;
  logic                  rs_sat;
  logic signed [W-1:0]   base;
  logic signed [SW-1:0]  sum_wide;
  logic signed [W-1:0]   sum;
  logic                  asat;

  fxp_round_sat #(.W(W), .FRAC(FRAC)) u_round_sat (
    .din  (prod2),
    .dout (rs_value),
    .sat  (rs_sat)
  );

  // S1..S3: operand capture, full-width product, rescaled product.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a1    <= '0;
      b1    <= '0;
      v1    <= 1'b0;
      l1    <= 1'b0;
      prod2 <= '0;
      v2    <= 1'b0;
      l2    <= 1'b0;
      p3    <= '0;
      v3    <= 1'b0;
      l3    <= 1'b0;
    end else if (enable) begin
      a1       <= A;
      b1       <= B;
      l1       <= in_last;
      prod2    <= (2*W)'(a1) * (2*W)'(b1);
      l2       <= l1;
      p3.value <= FXP_WMAX'(rs_value);
      p3.sat   <= rs_sat;
      l3       <= l2;
      if (clear) begin
        v1 <= 1'b0;
        v2 <= 1'b0;
        v3 <= 1'b0;
      end else begin
        v1 <= in_valid;
        v2 <= v1;
        v3 <= v2;
      end
    end
  end

  // S4 saturating add; the first sample of a frame starts from zero rather than acc.
  always_comb begin
    base     = first ? '0 : acc;
    sum_wide = SW'(base) + p3.value;
    sum      = sum_wide[W-1:0];
    asat     = 1'b0;
    if (sum_wide > SUM_MAX) begin
      sum  = SUM_MAX[W-1:0];
      asat = 1'b1;
    end else if (sum_wide < SUM_MIN) begin
      sum  = SUM_MIN[W-1:0];
      asat = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      first     <= 1'b1;
      frame_sat <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else if (enable) begin
      if (clear) begin
        acc       <= '0;
        first     <= 1'b1;
        frame_sat <= 1'b0;
        out_valid <= 1'b0;
      end else begin
        out_valid <= v3 && l3;
        if (v3) begin
          acc <= sum;
          if (l3) begin
            out_data  <= sum;
            out_sat   <= frame_sat | p3.sat | asat;
            frame_sat <= 1'b0;
            first     <= 1'b1;
          end else begin
            frame_sat <= frame_sat | p3.sat | asat;
            first     <= 1'b0;
          end
        end
      end
    end
  end

  assign acc_data = acc;

endmodule

// File: tb/tb_fxp_mac_pipe.sv
// Scenario bench for fxp_mac_pipe: a reference model pushes expected frame results
// at drive time; a monitor pops and compares them on each new out_valid pulse.
module tb_fxp_mac_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        clear;
  logic        in_valid;
  logic        in_last;
  logic [15:0] A;
  logic [15:0] B;
  logic [15:0] acc_data;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_sat;

  typedef struct {
    logic [15:0] data;
    logic        sat;
  } exp_t;

  exp_t   exp_q[$];
  exp_t   mon_e;
  int     checks = 0;
  int     errors = 0;
  logic   last_en = 1'b0;

  longint m_acc   = 0;
  logic   m_first = 1'b1;
  logic   m_fsat  = 1'b0;

  fxp_mac_pipe #(.W(16), .FRAC(9)) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .A         (A),
    .B         (B),
    .acc_data  (acc_data),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sat   (out_sat)
  );

  always #5 clk = ~clk;

  always @(posedge clk) last_en <= enable;

  // Only a pulse produced by an enabled edge is a new result; a held pulse is not.
  always @(negedge clk) begin
    if (!rst && out_valid && last_en) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL result_unexpected: got out_data=%h out_sat=%b, no result pending", out_data, out_sat);
      end else begin
        mon_e = exp_q.pop_front();
        if (out_data !== mon_e.data || out_sat !== mon_e.sat) begin
          errors++;
          $display("[TB] FAIL frame_result: got data=%h sat=%b, expected data=%h sat=%b",
                   out_data, out_sat, mon_e.data, mon_e.sat);
        end
      end
    end
  end

  function automatic void model_reset();
    m_acc   = 0;
    m_first = 1'b1;
    m_fsat  = 1'b0;
  endfunction

  function automatic void model_step(input logic [15:0] a, input logic [15:0] b, input logic l);
    longint p;
    longint s;
    logic   ps;
    logic   as;
    exp_t   e;
    p = longint'($signed(a)) * longint'($signed(b));
`ifdef FXP_MAC_ROUND_EN
    p = p + 256;
`endif
    p  = p >>> 9;
    ps = 1'b0;
    if (p > 32767) begin
      p  = 32767;
      ps = 1'b1;
    end else if (p < -32767) begin
      p  = -32767;
      ps = 1'b1;
    end
    s  = (m_first ? 0 : m_acc) + p;
    as = 1'b0;
    if (s > 32767) begin
      s  = 32767;
      as = 1'b1;
    end else if (s < -32767) begin
      s  = -32767;
      as = 1'b1;
    end
    m_acc   = s;
    m_first = 1'b0;
    m_fsat  = m_fsat | ps | as;
    if (l) begin
      e.data = 16'(s);
      e.sat  = m_fsat;
      exp_q.push_back(e);
      m_fsat  = 1'b0;
      m_first = 1'b1;
    end
  endfunction

  task automatic set_sample(input logic v, input logic l, input logic [15:0] a, input logic [15:0] b);
    enable   = 1'b1;
    clear    = 1'b0;
    in_valid = v;
    in_last  = l;
    A        = a;
    B        = b;
    if (v) model_step(a, b, l);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      set_sample(1'b0, 1'b0, 16'h0000, 16'h0000);
    end
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    enable   = 1'b0;
    clear    = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    A        = '0;
    B        = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({acc_data, out_data, out_valid, out_sat} !== 34'h0) begin
      errors++;
      $display("[TB] FAIL reset_state: got acc=%h data=%h valid=%b sat=%b, expected all zero",
               acc_data, out_data, out_valid, out_sat);
    end
    rst = 1'b0;
    idle(2);
  endtask

  task automatic test_frame4();
    logic [15:0] exp_acc;
    for (int t = 0; t < 9; t++) begin
      @(negedge clk);
      if (t >= 4 && t <= 7) begin
        exp_acc = 16'h0300 * 16'(t - 3);
        checks++;
        if (acc_data !== exp_acc) begin
          errors++;
          $display("[TB] FAIL frame4_acc t=%0d: got %h expected %h", t, acc_data, exp_acc);
        end
      end
      if (t == 6 || t == 7) begin
        checks++;
        if (out_valid !== (t == 7)) begin
          errors++;
          $display("[TB] FAIL frame4_latency t=%0d: got out_valid=%b expected %b", t, out_valid, t == 7);
        end
      end
      if (t < 4) set_sample(1'b1, t == 3, 16'h0200, 16'h0300);
      else       set_sample(1'b0, 1'b0, 16'h0000, 16'h0000);
    end
    idle(3);
  endtask

  task automatic test_saturation();
    @(negedge clk);
    set_sample(1'b1, 1'b1, 16'h7FFF, 16'h7FFF);
    @(negedge clk);
    set_sample(1'b1, 1'b1, 16'h8001, 16'h0200);
    idle(6);
    checks++;
    if (out_data !== 16'h8001 || out_sat !== 1'b0) begin
      errors++;
      $display("[TB] FAIL neg_full_scale: got data=%h sat=%b expected 8001/0", out_data, out_sat);
    end
  endtask

  task automatic test_rounding();
    logic [15:0] exp_d;
`ifdef FXP_MAC_ROUND_EN
    exp_d = 16'h0001;
`else
    exp_d = 16'h0000;
`endif
    @(negedge clk);
    set_sample(1'b1, 1'b1, 16'h0001, 16'h0100);
    idle(6);
    checks++;
    if (out_data !== exp_d) begin
      errors++;
      $display("[TB] FAIL rounding: got %h expected %h", out_data, exp_d);
    end
  endtask

  task automatic test_acc_saturation();
    logic [15:0] exp_acc;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      if (t >= 4 && t <= 7) begin
        case (t)
          4:       exp_acc = 16'h6000;
          7:       exp_acc = 16'h0200;
          default: exp_acc = 16'h7FFF;
        endcase
        checks++;
        if (acc_data !== exp_acc) begin
          errors++;
          $display("[TB] FAIL acc_sat t=%0d: got %h expected %h", t, acc_data, exp_acc);
        end
      end
      if (t < 3)       set_sample(1'b1, t == 2, 16'h6000, 16'h0200);
      else if (t == 3) set_sample(1'b1, 1'b1, 16'h0200, 16'h0200);
      else             set_sample(1'b0, 1'b0, 16'h0000, 16'h0000);
    end
    idle(2);
  endtask

  task automatic test_back_to_back();
    logic exp_v;
    for (int t = 0; t < 15; t++) begin
      @(negedge clk);
      if (t >= 6 && t <= 13) begin
        exp_v = (t == 8 || t == 11 || t == 12);
        checks++;
        if (out_valid !== exp_v) begin
          errors++;
          $display("[TB] FAIL b2b_valid t=%0d: got %b expected %b", t, out_valid, exp_v);
        end
      end
      case (t)
        0: set_sample(1'b1, 1'b0, 16'h0200, 16'h0100);
        1: set_sample(1'b1, 1'b0, 16'h0400, 16'h0100);
        2: set_sample(1'b1, 1'b1, 16'h0200, 16'h0080);
        3, 4: begin
          enable   = 1'b0;
          in_valid = 1'b1;
          in_last  = 1'b1;
          A        = 16'h7FFF;
          B        = 16'h7FFF;
        end
        6: set_sample(1'b1, 1'b0, 16'h0300, 16'h0200);
        7: set_sample(1'b1, 1'b1, 16'hFE00, 16'h0200);
        11: begin
          set_sample(1'b0, 1'b0, 16'h0000, 16'h0000);
          enable = 1'b0;
        end
        default: set_sample(1'b0, 1'b0, 16'h0000, 16'h0000);
      endcase
    end
    idle(2);
  endtask

  task automatic test_flush();
    // Reset in the middle of a partial frame.
    @(negedge clk);
    set_sample(1'b1, 1'b0, 16'h0200, 16'h0200);
    @(negedge clk);
    set_sample(1'b1, 1'b0, 16'h0200, 16'h0200);
    idle(2);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({acc_data, out_data, out_valid, out_sat} !== 34'h0) begin
      errors++;
      $display("[TB] FAIL async_reset: got acc=%h data=%h valid=%b sat=%b, expected all zero",
               acc_data, out_data, out_valid, out_sat);
    end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    set_sample(1'b1, 1'b0, 16'h0100, 16'h0200);
    @(negedge clk);
    set_sample(1'b1, 1'b1, 16'h0100, 16'h0200);
    idle(6);
    checks++;
    if (out_data !== 16'h0200) begin
      errors++;
      $display("[TB] FAIL post_reset_frame: got %h expected 0200", out_data);
    end
    // Clear in the middle of a partial frame.
    @(negedge clk);
    set_sample(1'b1, 1'b0, 16'h0400, 16'h0200);
    @(negedge clk);
    set_sample(1'b1, 1'b0, 16'h0400, 16'h0200);
    @(negedge clk);
    enable   = 1'b1;
    clear    = 1'b1;
    in_valid = 1'b1;
    in_last  = 1'b1;
    A        = 16'h1000;
    B        = 16'h1000;
    model_reset();
    @(negedge clk);
    checks++;
    if (acc_data !== 16'h0000 || out_valid !== 1'b0 || out_data !== 16'h0200) begin
      errors++;
      $display("[TB] FAIL clear_state: got acc=%h valid=%b data=%h expected 0000/0/0200",
               acc_data, out_valid, out_data);
    end
    set_sample(1'b0, 1'b0, 16'h0000, 16'h0000);
    idle(4);
    checks++;
    if (acc_data !== 16'h0000 || out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL clear_flushed: got acc=%h valid=%b expected 0000/0", acc_data, out_valid);
    end
    @(negedge clk);
    set_sample(1'b1, 1'b1, 16'h0200, 16'h0300);
    idle(6);
    checks++;
    if (out_data !== 16'h0300) begin
      errors++;
      $display("[TB] FAIL post_clear_frame: got %h expected 0300", out_data);
    end
  endtask

  initial begin
    test_reset();
    test_frame4();
    test_saturation();
    test_rounding();
    test_acc_saturation();
    test_back_to_back();
    test_flush();
    idle(4);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL results_drained: got %0d pending results, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fxp_mac_pipe.md
# fxp_mac_pipe

Parametrised, fully pipelined signed fixed-point multiply-accumulate unit for the datapath's MAC layer. It accepts one A/B operand pair per enabled cycle and rounds and saturates each product to the Q format. Products are summed per frame, and each frame's saturated sum is emitted with a valid pulse when the frame's last sample retires. A global enable stalls the pipeline, and a sticky flag reports any saturation that occurred within the frame.

## Interface
- `W`, 16: operand, product and accumulator width (two's complement), 4..32
- `FRAC`, 9: fractional bits of the Q format, 1..W-2
- `clk` in 1: clock, rising edge
- `rst` in 1: asynchronous, active-high reset
- `enable` in 1: pipeline advance; low freezes every stage register and every output
- `clear` in 1: synchronous flush of all stages and frame state; overrides `in_valid`
- `in_valid` in 1: `A`/`B`/`in_last` valid this cycle; sampled only when `enable`=1
- `in_last` in 1: marks the final sample of a frame
- `A`, `B` in W: signed Q(W-FRAC).FRAC operands
- `acc_data` out W: running accumulator, updated at stage 4
- `out_valid` out 1: one-cycle pulse carrying a frame result
- `out_data` out W: final frame sum, held until the next frame result
- `out_sat` out 1: asserted with `out_valid` if any product or add saturated in that frame

## Operation
- Saturation range is symmetric: MAX = 2^(W-1)-1 and MIN = -(2^(W-1)-1).
- The value -2^(W-1) is legal on the inputs but is never produced on any output.
- S1: register `A`, `B`, valid and last.
- S2: form the signed 2W-bit product.
- S3: add the rounding constant 2^(FRAC-1) (see Configuration), then arithmetic-shift right by FRAC. Clamp to [MIN, MAX] and set `psat` when clamped.
- S4: compute base = `first` ? 0 : acc. Compute sum = base + p at W+1 bits, clamp to [MIN, MAX], and set `asat` when clamped. Load acc with sum.
- `frame_sat` accumulates `psat`|`asat`. `first` is set at reset, after `clear`, and after every retired last sample; the first valid sample clears it.
- When a valid last sample retires at S4: load `out_data` with sum and pulse `out_valid`. Load `out_sat` with `frame_sat`|current sat. Clear `frame_sat` and set `first`.
- Invalid slots (bubbles) pass through without touching acc or the flags.
- A single-sample frame (`in_last` on the first sample) gives `out_data` = saturated, rounded product.
- `clear` while `enable`=1: zero all valid bits, set `first` to 1, clear `frame_sat` to 0 and acc to 0. `out_data` is held and `out_valid` is 0 next cycle.
- `clear` while `enable`=0: no effect.

## Timing
- Latency: an input sampled at edge n reaches S4 at edge n+3, so `out_valid` rises after edge n+3 counting enabled edges only.
- Throughput: one sample per enabled cycle with no bubbles required between frames.
- `out_valid` is high for exactly one enabled cycle. If `enable` drops in that cycle, `out_valid` stays high until the next enabled edge.
- Reset (async, any time including mid-frame):
  - zero all stage registers and valids
  - `acc_data`=0, `out_data`=0, `out_valid`=0, `out_sat`=0
  - `first`=1, `frame_sat`=0
- A partial frame is discarded on reset.

## Configuration
- `FXP_MAC_ROUND_EN` defined: S3 adds 2^(FRAC-1) before the shift (round half up).
- `FXP_MAC_ROUND_EN` undefined: no constant is added, so S3 truncates toward negative infinity.
- Saturation is identical in both builds.

## Structure
- `fxp_pkg` holds:
  - `FXP_MAX(W)` / `FXP_MIN(W)` constant functions
  - the `fxp_sat_t` struct {value, sat}
  - the rounding constant helper
- One sub-module, `fxp_round_sat` (params W, FRAC): combinational 2W-bit to W-bit round/shift/clamp with a sat output. Instantiated in S3.
- The saturating add is inline in S4.

## Test plan
All scenarios use the defaults W=16, FRAC=9 and `FXP_MAC_ROUND_EN` defined.
- Frame of 4 samples, each A=0x0200 (1.0) and B=0x0300 (1.5), last on the 4th: `out_valid` 3 cycles after the last input, `out_data`=0x0C00, `out_sat`=0. `acc_data` steps 0x0300, 0x0600, 0x0900, 0x0C00.
- Single sample A=0x7FFF, B=0x7FFF, last: `out_data`=0x7FFF, `out_sat`=1. Follow with A=0x8001, B=0x0200, last: `out_data`=0x8001, `out_sat`=0.
- Rounding: A=0x0001, B=0x0100, last: `out_data`=0x0001. The same stimulus in a build without the macro gives 0x0000.
- Accumulator saturation: 3 samples of 0x6000×0x0200: `acc_data` goes 0x6000, 0x7FFF, 0x7FFF and `out_sat`=1. The next frame (0x0200×0x0200) gives `out_sat`=0 and `out_data`=0x0200.
- Back-to-back frames with `enable` low for 2 cycles mid-frame and a bubble between frames: sums are unaffected, and `out_valid` is delayed exactly 2 cycles.
- `rst` pulsed mid-frame, then `clear` mid-frame in a second run: all outputs go to 0 (`out_data` is held on `clear`). The next frame's result excludes every pre-flush sample.
